// File: rtl/dmem_responder.sv
// Data-memory responder: single-outstanding load/store into a word-wide SRAM with byte lanes.
// Response registered one cycle after accept; req_ready stays low until the response is taken.
module dmem_responder #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_we,
  input  logic [3:0]  req_be,
  input  logic        req_signed,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state;
  logic [31:0] mem [DEPTH];
  logic [31:0] a_addr;
  logic [31:0] a_wdata;
  logic        a_we;
  logic [3:0]  a_be;
  logic        a_signed;
  logic [31:0] rd_word;

  logic [ADDR_WIDTH-1:0] a_idx;
  logic [1:0]            off;
  logic [4:0]            shamt;
  logic                  lane_ok;
  logic                  range_ok;
  logic                  legal;
  logic                  is_byte;
  logic                  is_half;
  logic                  wr_en;
  logic [31:0]           ld_shift;
  logic [31:0]           st_shift;
  logic [31:0]           ld_ext;

  assign req_ready = (state == IDLE) && resetb;

  assign a_idx    = a_addr[ADDR_WIDTH+1:2];
  assign off      = a_addr[1:0];
  assign shamt    = {off, 3'b000};
  assign range_ok = ~|a_addr[31:ADDR_WIDTH+2];
  assign legal    = lane_ok && range_ok;
  assign wr_en    = (state == ACCESS) && legal && a_we;
  assign ld_shift = rd_word >> shamt;
  assign st_shift = a_wdata << shamt;

  // Access size comes from the byte-enable pattern; the address must sit on that lane.
  always_comb begin
    lane_ok = 1'b0;
    is_byte = 1'b0;
    is_half = 1'b0;
    case (a_be)
      4'b0001: begin is_byte = 1'b1; lane_ok = (off == 2'd0); end
      4'b0010: begin is_byte = 1'b1; lane_ok = (off == 2'd1); end
      4'b0100: begin is_byte = 1'b1; lane_ok = (off == 2'd2); end
      4'b1000: begin is_byte = 1'b1; lane_ok = (off == 2'd3); end
      4'b0011: begin is_half = 1'b1; lane_ok = (off == 2'd0); end
      4'b1100: begin is_half = 1'b1; lane_ok = (off == 2'd2); end
      4'b1111: lane_ok = (off == 2'd0);
      default: lane_ok = 1'b0;
    endcase
  end

  always_comb begin
    ld_ext = ld_shift;
    if (is_byte)
      ld_ext = {{24{a_signed & ld_shift[7]}}, ld_shift[7:0]};
    else if (is_half)
      ld_ext = {{16{a_signed & ld_shift[15]}}, ld_shift[15:0]};
  end

  // SRAM port: read at accept, lane writes in ACCESS. Contents are never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++)
        if (a_be[i]) mem[a_idx][8*i +: 8] <= st_shift[8*i +: 8];
    end
    if (req_valid && req_ready)
      rd_word <= mem[req_addr[ADDR_WIDTH+1:2]];
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      a_addr    <= 32'd0;
      a_wdata   <= 32'd0;
      a_we      <= 1'b0;
      a_be      <= 4'd0;
      a_signed  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            a_addr   <= req_addr;
            a_wdata  <= req_wdata;
            a_we     <= req_we;
            a_be     <= req_be;
            a_signed <= req_signed;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          rsp_valid <= 1'b1;
          rsp_err   <= ~legal;
          rsp_rdata <= (legal && !a_we) ? ld_ext : 32'd0;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
